// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the core's M-stage load/store port
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   address       byte address from the core
//   write_data    unshifted store data (byte/half in low bits)
//   write_enable  single-cycle store strobe, never stalls
//   write_mask    unshifted lane mask (0001 byte, 0011 half, 1111 word); also the load size
//   read_enable   load request, held until read_valid
//   read_data     right-justified load data, holds outside the response cycle
//   read_valid    one-cycle load response pulse
//   misaligned    one-cycle pulse for a word-crossing access
// Optional: define DMEM_RANDOM_STALL_EN to add 0..3 LFSR-chosen cycles to each load latency.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h80000000,
  parameter int          DEPTH_WORDS  = 16384,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic [3:0]  write_mask,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        misaligned
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] w_off, w_lane_data, r_read_data;
  logic [AW-1:0] w_idx, r_idx, w_ld_idx;
  logic [1:0] w_b, r_b, w_ld_b;
  logic [3:0] w_lane_mask;
  logic [4:0] r_cnt, w_cnt_init;
  logic w_in_range, w_mis, r_ok, r_mis, w_ld_ok, w_ld_mis, w_enter_resp, r_misaligned;
  assign w_off       = address - BASE_ADDR;
  assign w_in_range  = w_off < 32'(DEPTH_WORDS * 4);
  assign w_idx       = w_off[AW+1:2];
  assign w_b         = address[1:0];
  assign w_mis       = (write_mask == 4'b0011 && w_b == 2'd3) || (write_mask == 4'b1111 && w_b != 2'd0);
  assign w_lane_mask = write_mask << w_b;
  assign w_lane_data = write_data << {w_b, 3'b000};
`ifdef DMEM_RANDOM_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk)
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  assign w_cnt_init = 5'(READ_LATENCY - 1) + {3'b000, r_lfsr[1:0]};
`else
  assign w_cnt_init = 5'(READ_LATENCY - 1);
`endif
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // WAIT exits to RESP on the edge where the counter decrements from 1 to 0
  always_comb begin
    w_next = r_state == IDLE ? (read_enable ? (w_cnt_init == 5'd0 ? RESP : WAIT) : IDLE) :
             r_state == WAIT ? (!read_enable ? IDLE : (r_cnt == 5'd1 ? RESP : WAIT)) : IDLE;
  end
  // A latency-1 load enters RESP on its accept edge, before the capture registers are loaded
  assign w_enter_resp = w_next == RESP;
  assign w_ld_idx     = r_state == IDLE ? w_idx : r_idx;
  assign w_ld_b       = r_state == IDLE ? w_b : r_b;
  assign w_ld_ok      = r_state == IDLE ? (w_in_range & ~w_mis) : r_ok;
  assign w_ld_mis     = r_state == IDLE ? w_mis : r_mis;
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_b          <= '0;
      r_ok         <= 1'b0;
      r_mis        <= 1'b0;
      r_read_data  <= '0;
      r_misaligned <= 1'b0;
    end else begin
      if (r_state == IDLE && read_enable) begin
        r_idx <= w_idx;
        r_b   <= w_b;
        r_ok  <= w_in_range & ~w_mis;
        r_mis <= w_mis;
        r_cnt <= w_cnt_init;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 5'd1;
      end
      if (w_enter_resp) r_read_data <= w_ld_ok ? r_mem[w_ld_idx] >> {w_ld_b, 3'b000} : 32'd0;
      r_misaligned <= (write_enable & w_mis) | (w_enter_resp & w_ld_mis);
    end
  // Array is never cleared; a same-edge load of this word sees the old contents
  always_ff @(posedge clk)
    if (write_enable && w_in_range && !w_mis)
      for (int i = 0; i < 4; i++)
        if (w_lane_mask[i]) r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
  assign read_data  = r_read_data;
  assign read_valid = r_state == RESP;
  assign misaligned = r_misaligned;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst, write_enable, read_enable, read_valid, misaligned;
  logic [31:0] address, write_data, read_data;
  logic [3:0] write_mask;
  int total = 0;
  int bad = 0;
  dmem_responder dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .write_enable(write_enable), .write_mask(write_mask), .read_enable(read_enable),
    .read_data(read_data), .read_valid(read_valid), .misaligned(misaligned)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_lat(input string tag, input int lat, input int base);
    total++;
`ifdef DMEM_RANDOM_STALL_EN
    assert (lat >= base && lat <= base + 3) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, lat, base, base + 3);
    end
`else
    assert (lat == base) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, lat, base);
    end
`endif
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    address = a; write_data = d; write_mask = m; write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [3:0] m, output logic [31:0] d, output int lat, output logic mis, output logic after);
    address = a; write_mask = m; read_enable = 1'b1; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (read_valid) begin lat = i; break; end
    end
    d = read_data; mis = misaligned;
    read_enable = 1'b0;
    @(posedge clk); #1;
    after = read_valid;
  endtask
  initial begin
    logic [31:0] d;
    logic mis, after, seen;
    int lat, gap;
    rst = 1'b1; write_enable = 1'b0; read_enable = 1'b0;
    address = '0; write_data = '0; write_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, read_valid}, 32'd0);
    chk("rst_data", read_data, 32'd0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);
    rst = 1'b0;
    wr(32'h80000010, 32'hDEADBEEF, 4'b1111);
    chk("wr_nomis", {31'b0, misaligned}, 32'd0);
    rd(32'h80000010, 4'b1111, d, lat, mis, after);
    chk("word_data", d, 32'hDEADBEEF);
    chk_lat("word_lat", lat, 2);
    chk("word_mis", {31'b0, mis}, 32'd0);
    chk("word_pulse", {31'b0, after}, 32'd0);
    chk("word_hold", read_data, 32'hDEADBEEF);
    wr(32'h80000020, 32'h11223344, 4'b1111);
    wr(32'h80000022, 32'h000000AA, 4'b0001);
    rd(32'h80000020, 4'b1111, d, lat, mis, after);
    chk("lane_word", d, 32'h11AA3344);
    rd(32'h80000023, 4'b0001, d, lat, mis, after);
    chk("lane_byte", d, 32'h00000011);
    rd(32'h80000022, 4'b0011, d, lat, mis, after);
    chk("lane_half", d, 32'h000011AA);
    address = 32'h80000010; write_mask = 4'b1111; read_enable = 1'b1; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (read_valid) begin lat = i; break; end
    end
    chk_lat("b2b_lat", lat, 2);
    chk("b2b_data1", read_data, 32'hDEADBEEF);
    gap = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) address = 32'h80000020;
      if (read_valid) begin gap = i; break; end
    end
    chk_lat("b2b_gap", gap, 3);
    chk("b2b_data2", read_data, 32'h11AA3344);
    read_enable = 1'b0;
    @(posedge clk); #1;
    rd(32'h7FFFFFFC, 4'b1111, d, lat, mis, after);
    chk_lat("oor_lat", lat, 2);
    chk("oor_data", d, 32'd0);
    wr(32'h80000012, 32'h55555555, 4'b1111);
    chk("mw_pulse", {31'b0, misaligned}, 32'd1);
    @(posedge clk); #1;
    chk("mw_clear", {31'b0, misaligned}, 32'd0);
    rd(32'h80000010, 4'b1111, d, lat, mis, after);
    chk("mw_unchanged", d, 32'hDEADBEEF);
    rd(32'h80000011, 4'b1111, d, lat, mis, after);
    chk_lat("mr_lat", lat, 2);
    chk("mr_data", d, 32'd0);
    chk("mr_mis", {31'b0, mis}, 32'd1);
    address = 32'h80000010; write_mask = 4'b1111; read_enable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; read_enable = 1'b0;
    chk("abort_rst0", {31'b0, read_valid}, 32'd0);
    @(posedge clk); #1;
    chk("abort_rst1", {31'b0, read_valid}, 32'd0);
    read_enable = 1'b1;
    @(posedge clk); #1;
    read_enable = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | read_valid;
    end
    chk("abort_drop", {31'b0, seen}, 32'd0);
    rd(32'h80000020, 4'b1111, d, lat, mis, after);
    chk("after_abort", d, 32'h11AA3344);
    chk_lat("after_abort_lat", lat, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
